// File: rtl/codec_cmd_arbiter_if.sv
// Requester-side request/response bus of codec_cmd_arbiter.
// master = requesters, slave = arbiter.
interface codec_cmd_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_wr;
  logic [8*NUM_REQ-1:0] req_addr;
  logic [9*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [8:0]           rsp_rdata;
  logic                 rsp_nack;
  logic                 rsp_timeout;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout
  );
endinterface

// File: rtl/codec_cmd_arbiter.sv
// Round-robin arbiter sharing the codec register command port between NUM_REQ requesters.
// Optional transaction watchdog: define CODEC_ARB_WATCHDOG_EN.
//
// state       | meaning
// IDLE        | wait for init_done, idle controller and a request; grant round-robin
// ISSUE       | emit the one-cycle codec_wr_en / codec_rd_en command pulse
// WAIT_BUSY   | wait for the controller to raise controller_busy
// WAIT_DONE   | capture read data and missed_ack until controller_busy falls
// RESP        | emit the one-cycle rsp_valid to the owner, advance rr_ptr
module codec_cmd_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic               clk,
  input  logic               reset,
  codec_cmd_arbiter_if.slave req_if,
  input  logic               init_done,
  output logic               codec_wr_en,
  output logic               codec_rd_en,
  output logic [7:0]         codec_reg_addr,
  output logic [8:0]         codec_data_in,
  input  logic               controller_busy,
  input  logic               codec_data_out_valid,
  input  logic [8:0]         codec_data_out,
  input  logic               missed_ack
);
  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 3) begin : g_param_check
    $error("codec_cmd_arbiter: unsupported parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RESP
  } state_t;

  state_t               r_state, w_state_nxt;
  logic   [PTR_W-1:0]   r_rr_ptr, r_gnt, w_gnt_idx, w_cand;
  logic                 w_gnt_any, w_grant, w_wd_hit;
  int                   w_idx;
  logic                 r_cmd_wr, r_cap_nack, r_cap_timeout;
  logic   [7:0]         r_cmd_addr;
  logic   [8:0]         r_cmd_wdata, r_cap_rdata;
  logic   [NUM_REQ-1:0] r_req_ready, r_rsp_valid;
  logic   [8:0]         r_rsp_rdata;
  logic                 r_rsp_nack, r_rsp_timeout;
  logic                 r_codec_wr_en, r_codec_rd_en;
  logic   [7:0]         r_codec_reg_addr;
  logic   [8:0]         r_codec_data_in;

  // First asserted requester at or after rr_ptr, wrapping
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    w_cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_cand = PTR_W'(w_idx);
      if (!w_gnt_any && req_if.req_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

`ifdef CODEC_ARB_WATCHDOG_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 18) ? $clog2(TIMEOUT_CYCLES + 1) : 18;
  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_wd_cnt <= '0;
    else if (r_state == S_ISSUE)
      r_wd_cnt <= '0;
    else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE)
      r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  // Expiry is decided two cycles early: RESP plus the registered response land on ISSUE+TIMEOUT
  assign w_wd_hit = (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE) &&
                    (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 3));
`else
  assign w_wd_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (init_done && !controller_busy && w_gnt_any) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_wd_hit)             w_state_nxt = S_RESP;
        else if (controller_busy) w_state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_wd_hit || !controller_busy) w_state_nxt = S_RESP;
      end
      S_RESP:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr         <= '0;
      r_gnt            <= '0;
      r_cmd_wr         <= 1'b0;
      r_cmd_addr       <= '0;
      r_cmd_wdata      <= '0;
      r_cap_rdata      <= '0;
      r_cap_nack       <= 1'b0;
      r_cap_timeout    <= 1'b0;
      r_req_ready      <= '0;
      r_rsp_valid      <= '0;
      r_rsp_rdata      <= '0;
      r_rsp_nack       <= 1'b0;
      r_rsp_timeout    <= 1'b0;
      r_codec_wr_en    <= 1'b0;
      r_codec_rd_en    <= 1'b0;
      r_codec_reg_addr <= '0;
      r_codec_data_in  <= '0;
    end else begin
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_nack    <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_codec_wr_en <= 1'b0;
      r_codec_rd_en <= 1'b0;

      if (w_grant) begin
        r_req_ready   <= NUM_REQ'(1) << w_gnt_idx;
        r_gnt         <= w_gnt_idx;
        r_cmd_wr      <= req_if.req_wr[w_gnt_idx];
        r_cmd_addr    <= req_if.req_addr[8*w_gnt_idx +: 8];
        r_cmd_wdata   <= req_if.req_wdata[9*w_gnt_idx +: 9];
        r_cap_rdata   <= '0;
        r_cap_nack    <= 1'b0;
        r_cap_timeout <= 1'b0;
      end

      if (r_state == S_ISSUE) begin
        r_codec_wr_en    <= r_cmd_wr;
        r_codec_rd_en    <= !r_cmd_wr;
        r_codec_reg_addr <= r_cmd_addr;
        r_codec_data_in  <= r_cmd_wdata;
      end

      if (r_state == S_WAIT_DONE) begin
        if (codec_data_out_valid && !r_cmd_wr) r_cap_rdata <= codec_data_out;
        if (missed_ack)                        r_cap_nack  <= 1'b1;
      end

      if (w_wd_hit) r_cap_timeout <= 1'b1;

      if (r_state == S_RESP) begin
        r_rsp_valid   <= NUM_REQ'(1) << r_gnt;
        r_rsp_rdata   <= (r_cmd_wr || r_cap_timeout) ? 9'h000 : r_cap_rdata;
        r_rsp_nack    <= r_cap_nack;
        r_rsp_timeout <= r_cap_timeout;
        r_rr_ptr      <= (r_gnt == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
      end
    end
  end

  assign req_if.req_ready   = r_req_ready;
  assign req_if.rsp_valid   = r_rsp_valid;
  assign req_if.rsp_rdata   = r_rsp_rdata;
  assign req_if.rsp_nack    = r_rsp_nack;
  assign req_if.rsp_timeout = r_rsp_timeout;
  assign codec_wr_en        = r_codec_wr_en;
  assign codec_rd_en        = r_codec_rd_en;
  assign codec_reg_addr     = r_codec_reg_addr;
  assign codec_data_in      = r_codec_data_in;
endmodule

// File: tb/tb_codec_cmd_arbiter.sv
// Directed bench for codec_cmd_arbiter (default build, watchdog not compiled in).
// The I2C controller is modelled inline by each scenario.
module tb_codec_cmd_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       init_done;
  logic       codec_wr_en, codec_rd_en;
  logic [7:0] codec_reg_addr;
  logic [8:0] codec_data_in;
  logic       controller_busy;
  logic       codec_data_out_valid;
  logic [8:0] codec_data_out;
  logic       missed_ack;

  int total = 0;
  int bad   = 0;

  codec_cmd_arbiter_if #(.NUM_REQ(2)) rif ();

  codec_cmd_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(64)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_if               (rif),
    .init_done            (init_done),
    .codec_wr_en          (codec_wr_en),
    .codec_rd_en          (codec_rd_en),
    .codec_reg_addr       (codec_reg_addr),
    .codec_data_in        (codec_data_in),
    .controller_busy      (controller_busy),
    .codec_data_out_valid (codec_data_out_valid),
    .codec_data_out       (codec_data_out),
    .missed_ack           (missed_ack)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Controller model: busy for len cycles, optional read-data pulse, missed_ack on the fall cycle.
  // Called in the cycle after the command pulse; returns in the RESP cycle.
  task automatic run_busy(input int len, input int dv_at, input logic [8:0] dv_val, input bit nack);
    controller_busy = 1'b1;
    for (int c = 0; c < len; c++) begin
      codec_data_out_valid = (c == dv_at);
      codec_data_out       = (c == dv_at) ? dv_val : 9'h000;
      tick();
    end
    codec_data_out_valid = 1'b0;
    codec_data_out       = 9'h000;
    controller_busy      = 1'b0;
    missed_ack           = nack;
    tick();
    missed_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] outs;
    reset = 1'b1;
    init_done = 1'b1;
    rif.req_valid = 2'b01;
    rif.req_wr = 2'b01;
    tick(3);
    outs = {rif.req_ready, rif.rsp_valid, rif.rsp_rdata, rif.rsp_nack, rif.rsp_timeout,
            codec_wr_en, codec_rd_en, codec_reg_addr, codec_data_in};
    total++;
    if (outs !== 36'h0) begin
      bad++; $display("FAIL reset_outs: got %h want 0", outs);
    end
    tick();
    total++;
    if (rif.req_ready !== 2'b00) begin
      bad++; $display("FAIL reset_no_grant: got %b want 00", rif.req_ready);
    end
    rif.req_valid = 2'b00;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_write();
    rif.req_wr    = 2'b01;
    rif.req_addr  = {8'h00, 8'h06};
    rif.req_wdata = {9'h000, 9'h1A5};
    rif.req_valid = 2'b01;
    tick();
    total++;
    if (rif.req_ready !== 2'b01) begin
      bad++; $display("FAIL wr_ready: got %b want 01", rif.req_ready);
    end
    total++;
    if (codec_wr_en !== 1'b0) begin
      bad++; $display("FAIL wr_cmd_early: got %b want 0", codec_wr_en);
    end
    rif.req_valid = 2'b00;
    tick();
    total++;
    if ({codec_wr_en, codec_rd_en, codec_reg_addr, codec_data_in} !== {1'b1, 1'b0, 8'h06, 9'h1A5}) begin
      bad++; $display("FAIL wr_cmd: got wr=%b rd=%b addr=%h data=%h want 1 0 06 1a5",
                      codec_wr_en, codec_rd_en, codec_reg_addr, codec_data_in);
    end
    tick();
    total++;
    if (codec_wr_en !== 1'b0) begin
      bad++; $display("FAIL wr_pulse_len: got %b want 0", codec_wr_en);
    end
    run_busy(50, -1, 9'h000, 1'b0);
    total++;
    if (rif.rsp_valid !== 2'b00) begin
      bad++; $display("FAIL wr_rsp_early: got %b want 00", rif.rsp_valid);
    end
    tick();
    total++;
    if ({rif.rsp_valid, rif.rsp_nack, rif.rsp_timeout, rif.rsp_rdata} !== {2'b01, 1'b0, 1'b0, 9'h000}) begin
      bad++; $display("FAIL wr_rsp: got valid=%b nack=%b to=%b rdata=%h want 01 0 0 000",
                      rif.rsp_valid, rif.rsp_nack, rif.rsp_timeout, rif.rsp_rdata);
    end
    tick();
    total++;
    if (rif.rsp_valid !== 2'b00) begin
      bad++; $display("FAIL wr_rsp_len: got %b want 00", rif.rsp_valid);
    end
  endtask

  task automatic test_read();
    rif.req_wr    = 2'b00;
    rif.req_addr  = {8'h04, 8'h00};
    rif.req_wdata = 18'h0;
    rif.req_valid = 2'b10;
    tick();
    total++;
    if (rif.req_ready !== 2'b10) begin
      bad++; $display("FAIL rd_ready: got %b want 10", rif.req_ready);
    end
    rif.req_valid = 2'b00;
    tick();
    total++;
    if ({codec_wr_en, codec_rd_en, codec_reg_addr} !== {1'b0, 1'b1, 8'h04}) begin
      bad++; $display("FAIL rd_cmd: got wr=%b rd=%b addr=%h want 0 1 04",
                      codec_wr_en, codec_rd_en, codec_reg_addr);
    end
    tick();
    controller_busy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      codec_data_out_valid = (c == 2 || c == 6);
      codec_data_out       = (c == 2) ? 9'h055 : (c == 6) ? 9'h0F3 : 9'h000;
      tick();
    end
    codec_data_out_valid = 1'b0;
    controller_busy      = 1'b0;
    tick(2);
    total++;
    if ({rif.rsp_valid, rif.rsp_rdata, rif.rsp_nack} !== {2'b10, 9'h0F3, 1'b0}) begin
      bad++; $display("FAIL rd_rsp: got valid=%b rdata=%h nack=%b want 10 0f3 0",
                      rif.rsp_valid, rif.rsp_rdata, rif.rsp_nack);
    end
    total++;
    if (codec_reg_addr !== 8'h04) begin
      bad++; $display("FAIL rd_addr_hold: got %h want 04", codec_reg_addr);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g, exp_g, prev_g;
    logic [7:0] exp_addr;
    int n;
    prev_g = 2'b00;
    rif.req_wr    = 2'b11;
    rif.req_addr  = {8'h21, 8'h10};
    rif.req_wdata = 18'h0;
    rif.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (rif.req_ready == 2'b00 && n < 20) begin
        tick(); n++;
      end
      g        = rif.req_ready;
      exp_g    = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (k % 2 == 0) ? 8'h10 : 8'h21;
      total++;
      if (g !== exp_g) begin
        bad++; $display("FAIL rr_grant%0d: got %b want %b", k, g, exp_g);
      end
      total++;
      if (g === prev_g) begin
        bad++; $display("FAIL rr_back_to_back%0d: got %b twice, want alternation", k, g);
      end
      prev_g = g;
      tick();
      total++;
      if (codec_wr_en !== 1'b1 || codec_reg_addr !== exp_addr) begin
        bad++; $display("FAIL rr_cmd%0d: got wr=%b addr=%h want 1 %h", k, codec_wr_en, codec_reg_addr, exp_addr);
      end
      tick();
      run_busy(5, -1, 9'h000, 1'b0);
      n = 0;
      while (rif.rsp_valid == 2'b00 && n < 10) begin
        tick(); n++;
      end
      total++;
      if (rif.rsp_valid !== exp_g) begin
        bad++; $display("FAIL rr_rsp%0d: got %b want %b", k, rif.rsp_valid, exp_g);
      end
      if (k == 3) rif.req_valid = 2'b00;
    end
    tick(2);
  endtask

  task automatic test_gating();
    int gate_bad;
    init_done     = 1'b0;
    rif.req_wr    = 2'b00;
    rif.req_addr  = {8'h00, 8'h33};
    rif.req_valid = 2'b01;
    gate_bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rif.req_ready !== 2'b00) gate_bad++;
    end
    total++;
    if (gate_bad != 0) begin
      bad++; $display("FAIL gate_hold: got %0d grant cycles want 0", gate_bad);
    end
    init_done = 1'b1;
    total++;
    if (rif.req_ready !== 2'b00) begin
      bad++; $display("FAIL gate_T: got %b want 00", rif.req_ready);
    end
    tick();
    total++;
    if (rif.req_ready !== 2'b01) begin
      bad++; $display("FAIL gate_T1: got %b want 01", rif.req_ready);
    end
    rif.req_valid = 2'b00;
    tick();
    total++;
    if (codec_rd_en !== 1'b1 || codec_reg_addr !== 8'h33) begin
      bad++; $display("FAIL gate_cmd: got rd=%b addr=%h want 1 33", codec_rd_en, codec_reg_addr);
    end
    tick();
    run_busy(3, -1, 9'h000, 1'b0);
    tick();
    total++;
    if (rif.rsp_valid !== 2'b01 || rif.rsp_rdata !== 9'h000) begin
      bad++; $display("FAIL gate_rsp: got valid=%b rdata=%h want 01 000", rif.rsp_valid, rif.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_nack_reset();
    logic [35:0] outs;
    int stray;
    rif.req_wr    = 2'b01;
    rif.req_addr  = {8'h00, 8'h0A};
    rif.req_wdata = {9'h000, 9'h100};
    rif.req_valid = 2'b01;
    tick();
    total++;
    if (rif.req_ready !== 2'b01) begin
      bad++; $display("FAIL nk_ready: got %b want 01", rif.req_ready);
    end
    rif.req_valid = 2'b00;
    tick();
    total++;
    if (codec_wr_en !== 1'b1 || codec_data_in !== 9'h100) begin
      bad++; $display("FAIL nk_cmd: got wr=%b data=%h want 1 100", codec_wr_en, codec_data_in);
    end
    tick();
    run_busy(4, 2, 9'h1AA, 1'b1);
    tick();
    total++;
    if ({rif.rsp_valid, rif.rsp_nack, rif.rsp_rdata} !== {2'b01, 1'b1, 9'h000}) begin
      bad++; $display("FAIL nk_rsp: got valid=%b nack=%b rdata=%h want 01 1 000",
                      rif.rsp_valid, rif.rsp_nack, rif.rsp_rdata);
    end
    tick();

    rif.req_wr    = 2'b00;
    rif.req_addr  = {8'h05, 8'h00};
    rif.req_valid = 2'b10;
    tick();
    total++;
    if (rif.req_ready !== 2'b10) begin
      bad++; $display("FAIL ab_ready: got %b want 10", rif.req_ready);
    end
    rif.req_valid = 2'b00;
    tick();
    total++;
    if (codec_rd_en !== 1'b1 || codec_reg_addr !== 8'h05) begin
      bad++; $display("FAIL ab_cmd: got rd=%b addr=%h want 1 05", codec_rd_en, codec_reg_addr);
    end
    tick();
    controller_busy = 1'b1;
    tick(2);
    codec_data_out_valid = 1'b1;
    codec_data_out       = 9'h1FF;
    tick();
    codec_data_out_valid = 1'b0;
    codec_data_out       = 9'h000;
    reset           = 1'b1;
    controller_busy = 1'b0;
    tick();
    outs = {rif.req_ready, rif.rsp_valid, rif.rsp_rdata, rif.rsp_nack, rif.rsp_timeout,
            codec_wr_en, codec_rd_en, codec_reg_addr, codec_data_in};
    total++;
    if (outs !== 36'h0) begin
      bad++; $display("FAIL ab_reset_outs: got %h want 0", outs);
    end
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rif.rsp_valid !== 2'b00) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++; $display("FAIL ab_no_rsp: got %0d rsp cycles want 0", stray);
    end

    rif.req_wr    = 2'b11;
    rif.req_addr  = {8'h44, 8'h40};
    rif.req_valid = 2'b11;
    tick();
    total++;
    if (rif.req_ready !== 2'b01) begin
      bad++; $display("FAIL rst_rr_ptr: got %b want 01", rif.req_ready);
    end
    rif.req_valid = 2'b00;
    tick(2);
    run_busy(3, -1, 9'h000, 1'b0);
    tick();
    total++;
    if (rif.rsp_valid !== 2'b01) begin
      bad++; $display("FAIL rst_rsp: got %b want 01", rif.rsp_valid);
    end
  endtask

  initial begin
    reset                = 1'b1;
    init_done            = 1'b0;
    controller_busy      = 1'b0;
    codec_data_out_valid = 1'b0;
    codec_data_out       = 9'h000;
    missed_ack           = 1'b0;
    rif.req_valid        = 2'b00;
    rif.req_wr           = 2'b00;
    rif.req_addr         = 16'h0;
    rif.req_wdata        = 18'h0;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_gating();
    test_nack_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish before 200000");
    $fatal(1, "global timeout");
  end
endmodule
